// File: rtl/dma_read_data_to_fpga.sv
// Host-to-FPGA data mover: splits a put-data command into chunks, issues paired DMA-read and
// memory-write commands per chunk, and streams returned DMA beats straight into memory write data.
module dma_read_data_to_fpga #(
    parameter int unsigned MAX_CHUNK = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_put_data_cmd_valid,
    output logic              s_axis_put_data_cmd_ready,
    input  logic [127:0]      s_axis_put_data_cmd_data,
    output logic              axis_dma_read_cmd_valid,
    input  logic              axis_dma_read_cmd_ready,
    output logic [63:0]       axis_dma_read_cmd_addr,
    output logic [31:0]       axis_dma_read_cmd_len,
    input  logic              axis_dma_read_data_valid,
    output logic              axis_dma_read_data_ready,
    input  logic [511:0]      axis_dma_read_data_data,
    input  logic [63:0]       axis_dma_read_data_keep,
    input  logic              axis_dma_read_data_last,
    output logic              m_axis_mem_write_cmd_valid,
    input  logic              m_axis_mem_write_cmd_ready,
    output logic [63:0]       m_axis_mem_write_cmd_addr,
    output logic [31:0]       m_axis_mem_write_cmd_len,
    output logic              m_axis_mem_write_data_valid,
    input  logic              m_axis_mem_write_data_ready,
    output logic [511:0]      m_axis_mem_write_data_data,
    output logic [63:0]       m_axis_mem_write_data_keep,
    output logic              m_axis_mem_write_data_last,
    input  logic              s_axis_mem_write_sts_valid,
    output logic              s_axis_mem_write_sts_ready,
    input  logic [7:0]        s_axis_mem_write_sts_data,
    output logic [1:0][31:0]  status_reg
);

    localparam logic [2:0]  IDLE    = 3'd0;
    localparam logic [2:0]  CALC    = 3'd1;
    localparam logic [2:0]  CMD     = 3'd2;
    localparam logic [2:0]  DATA    = 3'd3;
    localparam logic [2:0]  STS     = 3'd4;
    localparam logic [31:0] MAX_LEN = MAX_CHUNK;

    logic [2:0]  state_r;
    logic [63:0] host_addr_r;
    logic [31:0] mem_addr_r;
    logic [31:0] rem_len_r;
    logic [31:0] chunk_len_r;
    logic [31:0] beats_r;
    logic [31:0] beat_cnt_r;
    logic        dma_cmd_valid_r;
    logic        mem_cmd_valid_r;
    logic [31:0] put_count_r;
    logic        misaligned_r;
    logic        wr_err_r;
    logic        last_mismatch_r;

    logic        put_fire_s;
    logic [31:0] put_len_s;
    logic [31:0] chunk_s;
    logic        beat_fire_s;
    logic        gen_last_s;
    logic        sts_fire_s;
    logic [31:0] rem_after_s;

    // Handshake decode and chunk arithmetic
    always_comb begin
        put_fire_s  = (state_r == IDLE) && s_axis_put_data_cmd_valid;
        put_len_s   = s_axis_put_data_cmd_data[127:96] & 32'hFFFF_FFC0;
        chunk_s     = (rem_len_r < MAX_LEN) ? rem_len_r : MAX_LEN;
        beat_fire_s = (state_r == DATA) && axis_dma_read_data_valid && m_axis_mem_write_data_ready;
        gen_last_s  = (beat_cnt_r == (beats_r - 32'd1));
        sts_fire_s  = (state_r == STS) && s_axis_mem_write_sts_valid;
        rem_after_s = rem_len_r - chunk_len_r;
    end

    // Output mapping; the data path is a straight combinational pass-through while in DATA
    always_comb begin
        s_axis_put_data_cmd_ready   = (state_r == IDLE);
        axis_dma_read_cmd_valid     = dma_cmd_valid_r;
        axis_dma_read_cmd_addr      = host_addr_r;
        axis_dma_read_cmd_len       = chunk_len_r;
        m_axis_mem_write_cmd_valid  = mem_cmd_valid_r;
        m_axis_mem_write_cmd_addr   = {32'h0000_0000, mem_addr_r};
        m_axis_mem_write_cmd_len    = chunk_len_r;
        axis_dma_read_data_ready    = (state_r == DATA) ? m_axis_mem_write_data_ready : 1'b0;
        m_axis_mem_write_data_valid = (state_r == DATA) ? axis_dma_read_data_valid : 1'b0;
        m_axis_mem_write_data_data  = axis_dma_read_data_data;
        m_axis_mem_write_data_keep  = axis_dma_read_data_keep;
        m_axis_mem_write_data_last  = (state_r == DATA) ? gen_last_s : 1'b0;
        s_axis_mem_write_sts_ready  = (state_r == STS);
        status_reg[0]               = put_count_r;
        status_reg[1]               = {28'h000_0000, last_mismatch_r, wr_err_r, misaligned_r,
                                       (state_r != IDLE)};
    end

    // Transfer state machine, chunk bookkeeping and sticky status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            host_addr_r     <= 64'h0;
            mem_addr_r      <= 32'h0;
            rem_len_r       <= 32'h0;
            chunk_len_r     <= 32'h0;
            beats_r         <= 32'h0;
            beat_cnt_r      <= 32'h0;
            dma_cmd_valid_r <= 1'b0;
            mem_cmd_valid_r <= 1'b0;
            put_count_r     <= 32'h0;
            misaligned_r    <= 1'b0;
            wr_err_r        <= 1'b0;
            last_mismatch_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (put_fire_s) begin
                        host_addr_r <= s_axis_put_data_cmd_data[63:0];
                        mem_addr_r  <= s_axis_put_data_cmd_data[95:64];
                        rem_len_r   <= put_len_s;
                        if (s_axis_put_data_cmd_data[101:96] != 6'd0) begin
                            misaligned_r <= 1'b1;
                        end
                        // A request shorter than one beat completes without touching either side
                        if (put_len_s == 32'd0) begin
                            put_count_r <= put_count_r + 32'd1;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    chunk_len_r     <= chunk_s;
                    beats_r         <= chunk_s >> 6;
                    beat_cnt_r      <= 32'd0;
                    dma_cmd_valid_r <= 1'b1;
                    mem_cmd_valid_r <= 1'b1;
                    state_r         <= CMD;
                end
                CMD: begin
                    if (axis_dma_read_cmd_ready) begin
                        dma_cmd_valid_r <= 1'b0;
                    end
                    if (m_axis_mem_write_cmd_ready) begin
                        mem_cmd_valid_r <= 1'b0;
                    end
                    if ((!dma_cmd_valid_r || axis_dma_read_cmd_ready) &&
                        (!mem_cmd_valid_r || m_axis_mem_write_cmd_ready)) begin
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (beat_fire_s) begin
                        if (axis_dma_read_data_last != gen_last_s) begin
                            last_mismatch_r <= 1'b1;
                        end
                        if (gen_last_s) begin
                            beat_cnt_r <= 32'd0;
                            state_r    <= STS;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 32'd1;
                        end
                    end
                end
                STS: begin
                    if (sts_fire_s) begin
                        if (s_axis_mem_write_sts_data != 8'h00) begin
                            wr_err_r <= 1'b1;
                        end
                        host_addr_r <= host_addr_r + {32'h0000_0000, chunk_len_r};
                        mem_addr_r  <= mem_addr_r + chunk_len_r;
                        rem_len_r   <= rem_after_s;
                        if (rem_after_s == 32'd0) begin
                            put_count_r <= put_count_r + 32'd1;
                            state_r     <= IDLE;
                        end else begin
                            state_r <= CALC;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_read_data_to_fpga.sv
// Directed-plus-random bench for dma_read_data_to_fpga; expected chunking, payloads and status
// are computed from the transfer rules with plain arithmetic.
module tb_dma_read_data_to_fpga;

    localparam int unsigned MAX = 4096;

    logic              clk = 1'b0;
    logic              rst;
    logic              put_valid, put_ready;
    logic [127:0]      put_data;
    logic              dcmd_valid, dcmd_ready;
    logic [63:0]       dcmd_addr;
    logic [31:0]       dcmd_len;
    logic              dd_valid, dd_ready, dd_last;
    logic [511:0]      dd_data;
    logic [63:0]       dd_keep;
    logic              mcmd_valid, mcmd_ready;
    logic [63:0]       mcmd_addr;
    logic [31:0]       mcmd_len;
    logic              md_valid, md_ready, md_last;
    logic [511:0]      md_data;
    logic [63:0]       md_keep;
    logic              sts_valid, sts_ready;
    logic [7:0]        sts_data;
    logic [1:0][31:0]  status_reg;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_count = 0;
    logic exp_mis = 1'b0, exp_err = 1'b0, exp_mm = 1'b0;

    always #5 clk = ~clk;

    dma_read_data_to_fpga #(.MAX_CHUNK(MAX)) dut (
        .clk(clk), .rst(rst),
        .s_axis_put_data_cmd_valid(put_valid), .s_axis_put_data_cmd_ready(put_ready),
        .s_axis_put_data_cmd_data(put_data),
        .axis_dma_read_cmd_valid(dcmd_valid), .axis_dma_read_cmd_ready(dcmd_ready),
        .axis_dma_read_cmd_addr(dcmd_addr), .axis_dma_read_cmd_len(dcmd_len),
        .axis_dma_read_data_valid(dd_valid), .axis_dma_read_data_ready(dd_ready),
        .axis_dma_read_data_data(dd_data), .axis_dma_read_data_keep(dd_keep),
        .axis_dma_read_data_last(dd_last),
        .m_axis_mem_write_cmd_valid(mcmd_valid), .m_axis_mem_write_cmd_ready(mcmd_ready),
        .m_axis_mem_write_cmd_addr(mcmd_addr), .m_axis_mem_write_cmd_len(mcmd_len),
        .m_axis_mem_write_data_valid(md_valid), .m_axis_mem_write_data_ready(md_ready),
        .m_axis_mem_write_data_data(md_data), .m_axis_mem_write_data_keep(md_keep),
        .m_axis_mem_write_data_last(md_last),
        .s_axis_mem_write_sts_valid(sts_valid), .s_axis_mem_write_sts_ready(sts_ready),
        .s_axis_mem_write_sts_data(sts_data),
        .status_reg(status_reg)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_status(input logic busy);
        chk("status_count", status_reg[0], exp_count);
        chk("status_flags", status_reg[1], {28'd0, exp_mm, exp_err, exp_mis, busy});
    endtask

    // One put command end to end; entered and left at a negedge with the DUT idle
    task automatic run_put(input logic [63:0] host, input logic [31:0] mem, input logic [31:0] len,
                           input int mem_delay, input int bp_pct, input int err_chunk,
                           input int bad_last);
        logic [31:0]  rem, c, m, beats, b;
        logic [63:0]  h;
        logic [511:0] cur_d;
        logic [63:0]  cur_k;
        logic         dv, mr;
        int           nchunk, cyc;
        rem = len & 32'hFFFF_FFC0;
        h = host;  m = mem;  nchunk = 0;
        if (len[5:0] != 6'd0) exp_mis = 1'b1;
        chk("put_ready_idle", put_ready, 1'b1);
        put_valid = 1'b1;  put_data = {len, mem, host};
        @(posedge clk); @(negedge clk);
        put_valid = 1'b0;
        if (rem == 32'd0) begin
            exp_count++;
            chk("zero_dma_cmd", dcmd_valid, 1'b0);
            chk("zero_mem_cmd", mcmd_valid, 1'b0);
            chk_status(1'b0);
            return;
        end
        while (rem != 32'd0) begin
            c = (rem > MAX) ? MAX : rem;
            beats = c >> 6;
            chk("calc_dma_valid", dcmd_valid, 1'b0);
            chk("calc_busy", status_reg[1][0], 1'b1);
            @(negedge clk);
            chk("cmd_dma_valid", dcmd_valid, 1'b1);
            chk("cmd_dma_addr", dcmd_addr, h);
            chk("cmd_dma_len", dcmd_len, c);
            chk("cmd_mem_valid", mcmd_valid, 1'b1);
            chk("cmd_mem_addr", mcmd_addr, {32'd0, m});
            chk("cmd_mem_len", mcmd_len, c);
            dcmd_ready = 1'b1;  mcmd_ready = (mem_delay == 0);
            dd_valid = 1'b1;  md_ready = 1'b1;
            #1;
            chk("cmd_no_beat_rdy", dd_ready, 1'b0);
            chk("cmd_no_beat_vld", md_valid, 1'b0);
            @(posedge clk); @(negedge clk);
            for (int i = 1; i <= mem_delay; i++) begin
                chk("stag_dma_valid", dcmd_valid, 1'b0);
                chk("stag_mem_valid", mcmd_valid, 1'b1);
                chk("stag_mem_addr", mcmd_addr, {32'd0, m});
                chk("stag_no_beat", dd_ready, 1'b0);
                if (i == mem_delay) mcmd_ready = 1'b1;
                @(posedge clk); @(negedge clk);
            end
            dcmd_ready = 1'b0;  mcmd_ready = 1'b0;
            chk("cmds_done_dma", dcmd_valid, 1'b0);
            chk("cmds_done_mem", mcmd_valid, 1'b0);
            b = 32'd0;  cyc = 0;
            cur_d = rand512();  cur_k = {$urandom, $urandom};
            while (b < beats && cyc < 40 * int'(beats) + 50) begin
                dv = ($urandom_range(0, 99) < 85);
                mr = ($urandom_range(0, 99) >= bp_pct);
                dd_valid = dv;  dd_data = cur_d;  dd_keep = cur_k;  md_ready = mr;
                dd_last = (b == beats - 32'd1) || (nchunk == 0 && int'(b) == bad_last);
                #1;
                chk("data_valid", md_valid, dv);
                chk("data_ready", dd_ready, mr);
                chk("data_payload", md_data, cur_d);
                chk("data_keep", md_keep, cur_k);
                chk("data_last", md_last, (b == beats - 32'd1));
                @(posedge clk);
                if (dv && mr) begin
                    if (nchunk == 0 && int'(b) == bad_last && b != beats - 32'd1) exp_mm = 1'b1;
                    b = b + 32'd1;
                    cur_d = rand512();  cur_k = {$urandom, $urandom};
                end
                @(negedge clk);
                cyc++;
            end
            if (b < beats) chk("data_timeout", b, beats);
            dd_valid = 1'b1;  dd_last = 1'b0;  md_ready = 1'b1;
            #1;
            chk("sts_gate_valid", md_valid, 1'b0);
            chk("sts_gate_ready", dd_ready, 1'b0);
            chk("sts_ready", sts_ready, 1'b1);
            sts_valid = 1'b1;
            sts_data = (nchunk == err_chunk) ? 8'h01 : 8'h00;
            if (nchunk == err_chunk) exp_err = 1'b1;
            @(posedge clk); @(negedge clk);
            sts_valid = 1'b0;  dd_valid = 1'b0;  md_ready = 1'b0;
            rem = rem - c;  h = h + {32'd0, c};  m = m + c;  nchunk++;
        end
        exp_count++;
        chk("end_put_ready", put_ready, 1'b1);
        chk_status(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        put_valid = 1'b0;  put_data = '0;  dcmd_ready = 1'b0;  mcmd_ready = 1'b0;
        dd_valid = 1'b0;  dd_data = '0;  dd_keep = '0;  dd_last = 1'b0;  md_ready = 1'b0;
        sts_valid = 1'b0;  sts_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_put_ready", put_ready, 1'b1);
        chk("rst_dma_cmd", dcmd_valid, 1'b0);
        chk("rst_mem_cmd", mcmd_valid, 1'b0);
        chk("rst_sts_ready", sts_ready, 1'b0);
        chk_status(1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_put(64'h0000_0000_1234_0000, 32'h0000_4000, 32'h0000_0400, 0, 0, -1, -1);
        run_put({$urandom, $urandom}, $urandom, 32'd10000, 0, 30, -1, -1);
        run_put(64'h0000_0000_0000_8000, 32'h0001_0000, 32'h0000_0400, 5, 50, -1, -1);
        run_put(64'h0000_0000_0000_2000, 32'h0000_0040, 32'h0000_0045, 0, 0, -1, -1);
        run_put(64'h0000_0000_0000_3000, 32'h0000_0080, 32'h0000_0020, 0, 0, -1, -1);
        run_put(64'h0000_0000_0000_4000, 32'h0000_0100, 32'h0000_0100, 0, 20, 0, -1);
        run_put(64'h0000_0000_0000_5000, 32'h0000_0200, 32'h0000_0400, 1, 20, -1, 2);
        run_put(64'hFFFF_FFFF_FFFF_F000, 32'hFFFF_F800, 32'h0000_2000, 2, 10, -1, -1);
        for (int k = 0; k < 4; k++) begin
            run_put({$urandom, $urandom}, $urandom, $urandom_range(0, 6000),
                    $urandom_range(0, 3), $urandom_range(0, 60), -1, -1);
        end

        // Reset while beats are flowing
        put_valid = 1'b1;  put_data = {32'h0000_0400, 32'h0000_0000, 64'h0000_0000_0000_0000};
        @(posedge clk); @(negedge clk);
        put_valid = 1'b0;
        @(negedge clk);
        dcmd_ready = 1'b1;  mcmd_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        dcmd_ready = 1'b0;  mcmd_ready = 1'b0;
        dd_valid = 1'b1;  md_ready = 1'b1;  dd_data = rand512();
        @(posedge clk); @(negedge clk);
        chk("pre_rst_in_data", md_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        exp_count = 0;  exp_mis = 1'b0;  exp_err = 1'b0;  exp_mm = 1'b0;
        chk("midrst_put_ready", put_ready, 1'b1);
        chk("midrst_md_valid", md_valid, 1'b0);
        chk("midrst_dd_ready", dd_ready, 1'b0);
        chk("midrst_dma_cmd", dcmd_valid, 1'b0);
        chk("midrst_mem_cmd", mcmd_valid, 1'b0);
        chk("midrst_sts_ready", sts_ready, 1'b0);
        chk_status(1'b0);
        rst = 1'b0;  dd_valid = 1'b0;  md_ready = 1'b0;
        @(negedge clk);
        run_put(64'h0000_0000_0000_6000, 32'h0000_0300, 32'h0000_0180, 0, 25, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
